elastic_pipe_reg: RTL and testbench
===================================

Name: elastic_pipe_reg

Overview:
- Parametrised, handshaked pipeline register chain; the next generation of the fixed-field stage registers between IF/ID/EX/MEM/WB.
- Carries an opaque WIDTH-bit payload through DEPTH elastic stages with valid/ready flow control, a global pause, and a synchronous flush.
- Invalid slots present a configurable bubble value (e.g. NOP encoding).
- Each stage is a 2-entry skid buffer: full throughput, registered upstream ready.

Parameters:
WIDTH, 32, payload width in bits
DEPTH, 1, number of elastic stages; 0 = combinational pass-through
BUBBLE_VALUE, {WIDTH{1'b0}}, payload presented/stored when a slot is empty or flushed

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
pause  in  1  freeze all state; blocks both handshakes
flush  in  1  synchronous clear of every stage (bubble insertion)
in_valid  in  1  upstream payload valid
in_ready  out  1  chain accepts payload this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  payload at head is valid
out_ready  in  1  downstream accepts head payload
out_data  out  WIDTH  head payload; BUBBLE_VALUE when out_valid=0
occupancy  out  $clog2(2*DEPTH+1) (min 1)  count of valid entries in chain

Behaviour:
- Reset (reset_n=0, immediate, no clock needed):
  - all main/skid valid bits 0; all data regs = BUBBLE_VALUE.
  - out_valid=0, out_data=BUBBLE_VALUE, occupancy=0, in_ready=~pause.
- Per stage, state = main (m_valid, m_data) + skid (s_valid, s_data):
  - stage in_ready = ~s_valid (registered); stage out_valid = m_valid; stage out_data = m_valid ? m_data : BUBBLE_VALUE.
  - accept = in_valid & in_ready; drain = m_valid & out_ready.
  - If ~m_valid or drain:
    - if s_valid: m <= s, s_valid <= 0
    - else if accept: m <= in
    - else m_valid <= 0, m_data <= BUBBLE_VALUE
  - Else (main full, held): if accept: s <= in, s_valid <= 1.
  - Stages chain head-to-tail; stage k out feeds stage k+1 in.
- Top level:
  - in_ready = stage0 in_ready & ~pause.
  - out_valid = last m_valid & ~pause.
  - out_data follows the last stage.
- Latency: 1 cycle per stage (DEPTH cycles) when unblocked; throughput 1 payload/cycle; capacity 2*DEPTH.
- Ordering: strict FIFO order; no loss, no duplication under any out_ready pattern.
- Pause:
  - no register updates; no handshake fires.
  - occupancy and stored data held.
  - out_data still shows the head payload.
- Flush (priority over pause and handshakes):
  - next edge clears all valid bits and loads BUBBLE_VALUE into all data regs.
  - any payload offered/accepted in the flush cycle is dropped.
  - in_ready is forced 1 during flush; out_valid is forced 0.
- occupancy = combinational popcount of all m_valid/s_valid bits.
- Simultaneous accept and drain on a full main with empty skid: payload passes into main, skid stays empty (no stall).
- Reset mid-transfer: all in-flight payloads discarded, no partial state.
- DEPTH=0:
  - out_valid = in_valid & ~pause & ~flush; out_data = in_data.
  - in_ready = flush | (out_ready & ~pause).
  - occupancy = 0; no registers.

Decomposition:
- Shared package/defines: NOP encoding (default BUBBLE_VALUE for the IF/ID instance) and the occupancy-width helper macro.
- One sub-module: elastic_stage (WIDTH, BUBBLE_VALUE; single skid-buffer stage with flush/pause inputs).
- The top instantiates DEPTH of these via generate and handles the DEPTH=0 bypass.

Test Plan:
- WIDTH=32, DEPTH=2, BUBBLE_VALUE=0x13. out_ready=1; stream 0x1,0x2,0x3,... every cycle → first out_valid 2 cycles after first accept; outputs in order, one per cycle; in_ready stays 1.
- out_ready=0; offer 5 words 0xA0..0xA4 → exactly 0xA0..0xA3 accepted; in_ready=0 after 4th; occupancy=4. Then out_ready=1 → 0xA0..0xA3 emitted in order; 0xA4 then accepted and emitted.
- Occupancy 3; assert flush one cycle while offering 0xFF → next cycle occupancy=0, out_valid=0, out_data=0x13; 0xFF never appears at output.
- Mid-stream, pause=1 for 3 cycles → in_ready=0, out_valid=0, occupancy and out_data constant. Release → stream resumes with no gap in sequence.
- Drop reset_n between edges at occupancy 2 → out_valid=0, out_data=0x13, occupancy=0 immediately. Release → new stream 0x55 emerges after 2 cycles.
- DEPTH=0 build: in_data=0xDEADBEEF, in_valid=1, out_ready toggling → out_data=0xDEADBEEF same cycle; in_ready mirrors out_ready; flush=1 gives out_valid=0, in_ready=1.

Source files
------------

// File: rtl/elastic_pipe_reg_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
// NOP_ENCODING is the usual bubble for an instruction-carrying (IF/ID) instance.
package elastic_pipe_reg_pkg;

   localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

   // Width of the occupancy count: holds 0..2*depth, never narrower than one bit.
   function automatic int occ_width(input int depth);
      return (depth < 1) ? 1 : $clog2(2 * depth + 1);
   endfunction

endpackage

// File: rtl/elastic_pipe_reg_stage.sv
// One elastic stage: main register plus skid register, so upstream ready is a
// flop output while a full payload per cycle can still flow through.
module elastic_stage
   import elastic_pipe_reg_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             pause,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             m_valid,
   output logic             s_valid
);

   logic             m_valid_q, m_valid_d;
   logic [WIDTH-1:0] m_data_q,  m_data_d;
   logic             s_valid_q, s_valid_d;
   logic [WIDTH-1:0] s_data_q,  s_data_d;
   logic             accept;
   logic             drain;

   assign in_ready  = ~s_valid_q;
   assign out_valid = m_valid_q;
   assign out_data  = m_valid_q ? m_data_q : BUBBLE_VALUE;
   assign m_valid   = m_valid_q;
   assign s_valid   = s_valid_q;

   assign accept = in_valid & ~s_valid_q & ~pause;
   assign drain  = m_valid_q & out_ready & ~pause;

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      if (flush) begin
         m_valid_d = 1'b0;
         m_data_d  = BUBBLE_VALUE;
         s_valid_d = 1'b0;
         s_data_d  = BUBBLE_VALUE;
      end else if (!pause) begin
         if (!m_valid_q || drain) begin
            // Skid content is always older than anything upstream, so it refills main first.
            if (s_valid_q) begin
               m_valid_d = 1'b1;
               m_data_d  = s_data_q;
               s_valid_d = 1'b0;
               s_data_d  = BUBBLE_VALUE;
            end else if (accept) begin
               m_valid_d = 1'b1;
               m_data_d  = in_data;
            end else begin
               m_valid_d = 1'b0;
               m_data_d  = BUBBLE_VALUE;
            end
         end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_valid_q <= 1'b0;
         m_data_q  <= BUBBLE_VALUE;
         s_valid_q <= 1'b0;
         s_data_q  <= BUBBLE_VALUE;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
      end
   end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Chain of DEPTH elastic stages with global pause and flush; DEPTH=0 collapses
// to a purely combinational pass-through.
module elastic_pipe_reg
   import elastic_pipe_reg_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter int               DEPTH        = 1,
   parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           pause,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH-1:0]               out_data,
   output logic [occ_width(DEPTH)-1:0]    occupancy
);

   localparam int OCC_W = occ_width(DEPTH);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign out_valid = in_valid & ~pause & ~flush;
         assign out_data  = in_data;
         assign in_ready  = flush | (out_ready & ~pause);
         assign occupancy = '0;
      end else begin : g_chain
         logic [DEPTH:0]   valid_chain;
         logic [DEPTH:0]   ready_chain;
         logic [WIDTH-1:0] data_chain [DEPTH+1];
         logic [DEPTH-1:0] m_valid_vec;
         logic [DEPTH-1:0] s_valid_vec;
         logic [OCC_W-1:0] occ_sum;

         assign valid_chain[0]     = in_valid;
         assign data_chain[0]      = in_data;
         assign ready_chain[DEPTH] = out_ready;

         for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            elastic_stage #(
               .WIDTH        (WIDTH),
               .BUBBLE_VALUE (BUBBLE_VALUE)
            ) u_stage (
               .clock     (clock),
               .reset_n   (reset_n),
               .pause     (pause),
               .flush     (flush),
               .in_valid  (valid_chain[gi]),
               .in_ready  (ready_chain[gi]),
               .in_data   (data_chain[gi]),
               .out_valid (valid_chain[gi+1]),
               .out_ready (ready_chain[gi+1]),
               .out_data  (data_chain[gi+1]),
               .m_valid   (m_valid_vec[gi]),
               .s_valid   (s_valid_vec[gi])
            );
         end

         always_comb begin
            occ_sum = '0;
            for (int i = 0; i < DEPTH; i++) begin
               occ_sum = occ_sum + OCC_W'(m_valid_vec[i]) + OCC_W'(s_valid_vec[i]);
            end
         end

         // Flush wins: offered payload is dropped, so upstream may as well see ready.
         assign in_ready  = flush | (ready_chain[0] & ~pause);
         assign out_valid = valid_chain[DEPTH] & ~pause & ~flush;
         assign out_data  = data_chain[DEPTH];
         assign occupancy = occ_sum;
      end
   endgenerate

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Self-checking bench: scoreboard-checked DEPTH=2 chain plus a vector table
// for the DEPTH=0 pass-through build.
module tb_elastic_pipe_reg;

   localparam logic [31:0] BUB = 32'h13;

   logic        clock;
   logic        reset_n;
   logic        pause, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] in_data, out_data;
   logic [2:0]  occupancy;

   logic        b_pause, b_flush, b_in_valid, b_out_ready;
   logic        b_in_ready, b_out_valid;
   logic [31:0] b_in_data, b_out_data;
   logic [0:0]  b_occupancy;

   int          n_vec = 0;
   int          n_err = 0;
   int          n_push = 0;
   int          n_pop = 0;
   logic [31:0] sb [$];

   typedef struct {
      logic        iv;
      logic        ordy;
      logic        ps;
      logic        fl;
      logic [31:0] din;
      logic        exp_ov;
      logic        exp_ir;
      logic [31:0] exp_dout;
   } vec_t;
   vec_t vecs [8];

   elastic_pipe_reg #(.WIDTH(32), .DEPTH(2), .BUBBLE_VALUE(32'h13)) u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .pause     (pause),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   elastic_pipe_reg #(.WIDTH(32), .DEPTH(0), .BUBBLE_VALUE(32'h13)) u_byp (
      .clock     (clock),
      .reset_n   (reset_n),
      .pause     (b_pause),
      .flush     (b_flush),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .occupancy (b_occupancy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   // Scoreboard: push on input handshake, pop and compare on output handshake.
   always @(negedge clock) begin
      if (reset_n) begin
         if (flush) begin
            sb.delete();
         end else begin
            if (in_valid && in_ready) begin
               sb.push_back(in_data);
               n_push++;
            end
            if (out_valid && out_ready) begin
               n_pop++;
               if (sb.size() == 0) begin
                  chk("sb_unexpected_out", out_data, 32'hFFFF_FFFF);
               end else begin
                  chk("sb_order", out_data, sb.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n_sent;
      int n_out;
      int pops_before;
      logic sent;
      logic pz;

      vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678};

      reset_n = 1'b0; pause = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      b_pause = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;

      // Reset state
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, BUB);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_in_ready", in_ready, 1);
      #20;
      reset_n = 1'b1;
      cyc();

      // Full-rate stream: 2-cycle latency, one output per cycle
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in_valid = 1'b1;
         in_data  = i;
         smp();
         chk("stream_in_ready", in_ready, 1);
         if (i < 3) begin
            chk("stream_latency_ov", out_valid, 0);
         end else begin
            chk("stream_ov", out_valid, 1);
            chk("stream_data", out_data, i - 2);
         end
         cyc();
      end
      in_valid = 1'b0;
      repeat (4) begin smp(); cyc(); end
      smp();
      chk("stream_drained_occ", occupancy, 0);
      cyc();

      // Backpressure: capacity of four words
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         in_data  = 32'hA0 + ((c < 4) ? c : 4);
         smp();
         chk("bp_in_ready", in_ready, (c < 4) ? 1 : 0);
         chk("bp_occupancy", occupancy, (c < 4) ? c : 4);
         cyc();
      end
      out_ready   = 1'b1;
      pops_before = n_pop;
      sent        = 1'b0;
      for (int c = 0; c < 10; c++) begin
         smp();
         if (c <= 2) chk("bp_release_in_ready", in_ready, (c == 2) ? 1 : 0);
         if (in_valid && in_ready) sent = 1'b1;
         cyc();
         if (sent) in_valid = 1'b0;
      end
      chk("bp_emitted_count", n_pop - pops_before, 5);
      smp();
      chk("bp_final_occ", occupancy, 0);
      cyc();

      // Flush at occupancy 3 while offering 0xFF
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_data  = 32'hB0 + c;
         smp();
         chk("fl_fill_in_ready", in_ready, 1);
         cyc();
      end
      in_valid = 1'b1;
      in_data  = 32'hFF;
      flush    = 1'b1;
      smp();
      chk("fl_occ_before", occupancy, 3);
      chk("fl_in_ready_forced", in_ready, 1);
      chk("fl_out_valid_forced", out_valid, 0);
      cyc();
      flush    = 1'b0;
      in_valid = 1'b0;
      smp();
      chk("fl_occ_after", occupancy, 0);
      chk("fl_out_valid_after", out_valid, 0);
      chk("fl_out_data_bubble", out_data, BUB);
      cyc();
      out_ready = 1'b1;
      repeat (3) begin
         smp();
         chk("fl_no_ghost", out_valid, 0);
         cyc();
      end

      // Pause for three cycles mid-stream
      n_sent = 0;
      n_out  = 0;
      for (int i = 0; i < 12; i++) begin
         pz       = (i >= 4 && i <= 6);
         pause    = pz;
         in_valid = 1'b1;
         in_data  = 32'hC1 + n_sent;
         smp();
         chk("pz_in_ready", in_ready, !pz);
         if (pz) begin
            chk("pz_out_valid", out_valid, 0);
            chk("pz_occupancy", occupancy, 2);
            chk("pz_out_data", out_data, 32'hC1 + n_out);
         end else if (i >= 2) begin
            chk("pz_stream_ov", out_valid, 1);
            chk("pz_stream_data", out_data, 32'hC1 + n_out);
            n_out++;
         end else begin
            chk("pz_latency_ov", out_valid, 0);
         end
         if (!pz) n_sent++;
         cyc();
      end
      pause    = 1'b0;
      in_valid = 1'b0;
      repeat (3) begin smp(); cyc(); end
      smp();
      chk("pz_drained_occ", occupancy, 0);
      cyc();

      // Asynchronous reset at occupancy 2
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1;
         in_data  = 32'hD0 + c;
         smp();
         cyc();
      end
      in_valid = 1'b0;
      chk("ar_occ_before", occupancy, 2);
      reset_n = 1'b0;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_out_data", out_data, BUB);
      chk("ar_occupancy", occupancy, 0);
      chk("ar_in_ready", in_ready, 1);
      sb.delete();
      smp();
      #2;
      reset_n = 1'b1;
      cyc();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h55;
      smp();
      chk("ar_new_lat0", out_valid, 0);
      cyc();
      in_valid = 1'b0;
      smp();
      chk("ar_new_lat1", out_valid, 0);
      cyc();
      smp();
      chk("ar_new_ov", out_valid, 1);
      chk("ar_new_data", out_data, 32'h55);
      cyc();
      repeat (2) begin smp(); cyc(); end
      chk("sb_empty", sb.size(), 0);

      // DEPTH=0 pass-through vectors
      for (int v = 0; v < 8; v++) begin
         b_in_valid  = vecs[v].iv;
         b_out_ready = vecs[v].ordy;
         b_pause     = vecs[v].ps;
         b_flush     = vecs[v].fl;
         b_in_data   = vecs[v].din;
         #1;
         chk($sformatf("byp%0d_out_valid", v), b_out_valid, vecs[v].exp_ov);
         chk($sformatf("byp%0d_in_ready", v), b_in_ready, vecs[v].exp_ir);
         chk($sformatf("byp%0d_out_data", v), b_out_data, vecs[v].exp_dout);
         chk($sformatf("byp%0d_occupancy", v), b_occupancy, 0);
         #4;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
